// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: controller states and the
// {pc, instr} record carried through the fetch buffer.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop and flush; the head entry is shown
// combinationally so decode sees it in the cycle it becomes valid.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       not_empty
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_pop_s  = pop && (count_r != {CW{1'b0}});
    // A full buffer may still accept a word when the head leaves in the same cycle.
    assign do_push_s = push && ((count_r < CW'(DEPTH)) || do_pop_s);

    // Occupancy update for the push/pop combination of this cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; flush empties the buffer at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign not_empty = (count_r != {CW{1'b0}});

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: walks the PC over the instruction memory,
// buffers {pc, instr} for decode and applies redirects / misalignment faults.
module imem_fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              INSTR_W    = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic [INSTR_W-1:0]            imem_instr,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTR_W-1:0]            out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fault,
    output logic [XLEN-1:0]               fault_pc
);
    import fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = XLEN + INSTR_W;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic            fault_r;
    logic [XLEN-1:0] fault_pc_r;
    logic            misalign_s;
    logic            pop_s;
    logic            req_s;
    logic            not_empty_s;
    logic [CW-1:0]   count_s;
    entry_t          push_entry_s;
    entry_t          head_entry_s;
    logic [EW-1:0]   head_bits_s;

    assign misalign_s = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign pop_s      = not_empty_s && out_ready;
    assign req_s      = (state_r == FETCH) && !redirect_valid &&
                        ((count_s < CW'(FIFO_DEPTH)) || pop_s);

    // Next-state selection; any redirect overrides the normal flow.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            if (misalign_s) begin
                state_nxt_s = FAULT;
            end else if (en) begin
                state_nxt_s = FETCH;
            end else begin
                state_nxt_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (en && !fault_r) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FETCH: begin
                    if (!en) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end
                FAULT:   state_nxt_s = FAULT;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, PC and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            fault_r    <= 1'b0;
            fault_pc_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (redirect_valid) begin
                if (misalign_s) begin
                    fault_r    <= 1'b1;
                    fault_pc_r <= redirect_pc;
                end else begin
                    fault_r <= 1'b0;
                    pc_r    <= redirect_pc;
                end
            end else if (req_s) begin
                pc_r <= pc_r + XLEN'(3'd4);
            end
        end
    end

    assign push_entry_s = '{pc: pc_r, instr: imem_instr};

    fetch_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_bits_s),
        .count     (count_s),
        .not_empty (not_empty_s)
    );

    assign head_entry_s = entry_t'(head_bits_s);

    assign imem_req   = req_s;
    assign imem_addr  = pc_r;
    assign out_valid  = not_empty_s;
    assign out_instr  = head_entry_s.instr;
    assign out_pc     = head_entry_s.pc;
    assign fifo_count = count_s;
    assign fault      = fault_r;
    assign fault_pc   = fault_pc_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; a second instance with a high RESET_PC
// covers PC wrap-around. Memory model: word = address ^ 32'hA5A5_0000.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  fifo_count;
    logic        fault;
    logic [31:0] fault_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr_in;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [1:0]  w_count;
    logic        w_fault;
    logic [31:0] w_fault_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr ^ 32'hA5A5_0000;
    assign w_instr_in = w_addr ^ 32'hA5A5_0000;

    imem_fetch_ctrl #(.XLEN(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_count(fifo_count), .fault(fault), .fault_pc(fault_pc)
    );

    imem_fetch_ctrl #(.XLEN(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(w_req), .imem_addr(w_addr), .imem_instr(w_instr_in),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .out_valid(w_valid), .out_ready(out_ready), .out_instr(w_instr),
        .out_pc(w_pc), .fifo_count(w_count), .fault(w_fault), .fault_pc(w_fault_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the middle of the next cycle; inputs set after this apply to that cycle.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        cyc(); cyc();
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {30'd0, fifo_count}, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0000_0000);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fpc",   fault_pc, 32'h0);
        chk("rst_waddr", w_addr, 32'hFFFF_FFF8);

        // Streaming: cycle 0 release
        cyc(); rst = 1'b0; en = 1'b1; out_ready = 1'b1; #1;
        chk("c0_req", {31'd0, imem_req}, 32'd0);
        cyc(); #1;
        chk("c1_req",   {31'd0, imem_req}, 32'd1);
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        chk("c2_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_pc",    out_pc, 32'h0);
        chk("c2_instr", out_instr, 32'hA5A5_0000);
        chk("c2_wpc",   w_pc, 32'hFFFF_FFF8);
        chk("c2_winstr", w_instr, 32'h5A5A_FFF8);
        cyc(); #1;
        chk("c3_pc",    out_pc, 32'h4);
        chk("c3_instr", out_instr, 32'hA5A5_0004);
        chk("c3_wpc",   w_pc, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("c4_pc",    out_pc, 32'h8);
        chk("c4_wpc",   w_pc, 32'h0000_0000);
        chk("c4_winstr", w_instr, 32'hA5A5_0000);

        // Reset mid-stream, then restart with decode stalled
        cyc(); rst = 1'b1;
        cyc(); #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_addr",  imem_addr, 32'h0);
        cyc(); rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        cyc(); cyc(); cyc(); #1;
        chk("st3_count", {30'd0, fifo_count}, 32'd2);
        chk("st3_req",   {31'd0, imem_req}, 32'd0);
        chk("st3_addr",  imem_addr, 32'h8);
        chk("st3_pc",    out_pc, 32'h0);
        cyc(); #1;
        chk("st4_count", {30'd0, fifo_count}, 32'd2);
        chk("st4_addr",  imem_addr, 32'h8);
        chk("st4_pc",    out_pc, 32'h0);
        cyc(); out_ready = 1'b1; #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_pc0", out_pc, 32'h0);
        cyc(); #1;
        chk("rel_pc4",   out_pc, 32'h4);
        chk("rel_count", {30'd0, fifo_count}, 32'd2);
        cyc(); #1;
        chk("rel_pc8", out_pc, 32'h8);
        cyc(); #1;
        chk("rel_pc12", out_pc, 32'hC);

        // Redirect while two entries are buffered
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b0; #1;
        chk("rd_count_before", {30'd0, fifo_count}, 32'd2);
        chk("rd_req", {31'd0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("rd_count", {30'd0, fifo_count}, 32'd0);
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_addr",  imem_addr, 32'h100);
        chk("rd_req1",  {31'd0, imem_req}, 32'd1);
        cyc(); out_ready = 1'b1; #1;
        chk("rd_valid2", {31'd0, out_valid}, 32'd1);
        chk("rd_pc",     out_pc, 32'h100);
        chk("rd_instr",  out_instr, 32'hA5A5_0100);
        cyc(); #1;
        chk("rd_pc2", out_pc, 32'h104);

        // Misaligned redirect, then recovery
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_fpc",   fault_pc, 32'h102);
        chk("mis_req1",  {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        chk("mis_req2",   {31'd0, imem_req}, 32'd0);
        chk("mis_fault2", {31'd0, fault}, 32'd1);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("rec_fault_hold", {31'd0, fault}, 32'd1);
        cyc(); redirect_valid = 1'b0; #1;
        chk("rec_fault", {31'd0, fault}, 32'd0);
        chk("rec_addr",  imem_addr, 32'h200);
        chk("rec_req",   {31'd0, imem_req}, 32'd1);
        cyc(); out_ready = 1'b0; #1;
        chk("rec_pc",    out_pc, 32'h200);
        chk("rec_valid", {31'd0, out_valid}, 32'd1);

        // Stop fetching with a full buffer, drain one, reset mid-drain
        cyc(); en = 1'b0; #1;
        chk("dr_count", {30'd0, fifo_count}, 32'd2);
        chk("dr_req",   {31'd0, imem_req}, 32'd0);
        cyc(); out_ready = 1'b1; #1;
        chk("dr_idle_req", {31'd0, imem_req}, 32'd0);
        chk("dr_hold_pc",  out_pc, 32'h200);
        cyc(); #1;
        chk("dr_count1", {30'd0, fifo_count}, 32'd1);
        chk("dr_pc",     out_pc, 32'h204);
        chk("dr_req2",   {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        cyc(); #1;
        chk("fin_valid", {31'd0, out_valid}, 32'd0);
        chk("fin_count", {30'd0, fifo_count}, 32'd0);
        chk("fin_addr",  imem_addr, 32'h0);
        chk("fin_req",   {31'd0, imem_req}, 32'd0);
        chk("fin_fault", {31'd0, fault}, 32'd0);
        chk("fin_fpc",   fault_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
